// File: rtl/clockworks_gearbox.sv
// clockworks_gearbox: clock-enable gearbox for single-stepping a design.
// It stretches the board reset into an active-low resetn. It also produces
// NCH independent one-cycle tick enables, each with its own runtime divisor,
// under a RUN / PAUSE / STEP mode FSM.
//
// Ports:
//   CLK      board clock (only clock)
//   RESET    synchronous active-high reset
//   mode     00 RUN, 01 PAUSE, 10 STEP, 11 PAUSE
//   step     step request level; its rising edge is detected internally
//   div      channel i divisor in [i*DIV_W +: DIV_W]; tick period = div_i+1
//   resetn   stretched active-low reset for the observed design (registered)
//   tick     per-channel one-cycle clock enables (registered)
//   running  high while the FSM is in RUN (registered)
module clockworks_gearbox #(
  parameter int unsigned NCH          = 2,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned RESET_CYCLES = 4096
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [1:0]             mode,
  input  logic                   step,
  input  logic [NCH*DIV_W-1:0]   div,
  output logic                   resetn,
  output logic [NCH-1:0]         tick,
  output logic                   running
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t            state;
  state_t            mode_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  cnt [NCH];
  logic              step_q;
  logic              step_edge;

  // Decode the mode pins; the reserved encoding behaves as PAUSE.
  always_comb begin
    mode_state = S_PAUSE;
    case (mode)
      2'b00:   mode_state = S_RUN;
      2'b10:   mode_state = S_STEP;
      default: mode_state = S_PAUSE;
    endcase
  end

  // step_q resets high so a step held through reset/hold is not an edge.
  assign step_edge = step & ~step_q;

  // Mode FSM, reset stretcher and channel counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      resetn   <= 1'b0;
      running  <= 1'b0;
      tick     <= '0;
      step_q   <= 1'b1;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      step_q <= step;
      if (state == S_HOLD) begin
        tick     <= '0;
        hold_cnt <= hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          resetn  <= 1'b1;
          state   <= mode_state;
          running <= (mode_state == S_RUN);
        end
      end else begin
        // Mode is acted on the edge it is sampled, not one cycle later.
        state   <= mode_state;
        running <= (mode_state == S_RUN);
        for (int i = 0; i < int'(NCH); i++) begin
          case (mode_state)
            S_RUN: begin
              // >= so a divisor lowered below the count fires immediately.
              if (cnt[i] >= div[i*DIV_W +: DIV_W]) begin
                cnt[i]  <= '0;
                tick[i] <= 1'b1;
              end else begin
                cnt[i]  <= cnt[i] + DIV_W'(1);
                tick[i] <= 1'b0;
              end
            end
            S_STEP: begin
              if (step_edge) begin
                cnt[i]  <= '0;
                tick[i] <= 1'b1;
              end else begin
                tick[i] <= 1'b0;
              end
            end
            default: begin
              tick[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_clockworks_gearbox.sv
// Testbench for clockworks_gearbox: a behavioural model checked every cycle,
// plus directed vectors with hand-computed expected values.
module tb_clockworks_gearbox;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned RC    = 16;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic [1:0]           mode;
  logic                 step;
  logic [NCH*DIV_W-1:0] div;
  logic                 resetn;
  logic [NCH-1:0]       tick;
  logic                 running;

  int n_tests = 0;
  int n_fail  = 0;

  clockworks_gearbox #(.NCH(NCH), .DIV_W(DIV_W), .RESET_CYCLES(RC)) dut (
    .CLK(CLK), .RESET(RESET), .mode(mode), .step(step), .div(div),
    .resetn(resetn), .tick(tick), .running(running)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: hold counter, per-channel counts, step edge memory.
  bit             m_valid = 1'b0;
  bit             m_inhold;
  int             m_hold;
  int             m_cnt [NCH];
  bit             m_stepq;
  bit             m_resetn;
  bit             m_running;
  bit [NCH-1:0]   m_tick;

  always @(posedge CLK) begin
    bit old_q;
    int d;
    if (RESET === 1'b1) begin
      m_valid = 1'b1; m_inhold = 1'b1; m_hold = 0; m_stepq = 1'b1;
      m_resetn = 1'b0; m_running = 1'b0; m_tick = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else if (m_valid) begin
      old_q   = m_stepq;
      m_stepq = step;
      if (m_inhold) begin
        m_hold++;
        m_tick = '0;
        if (m_hold == RC) begin
          m_inhold  = 1'b0;
          m_resetn  = 1'b1;
          m_running = (mode == 2'b00);
        end
      end else begin
        m_running = (mode == 2'b00);
        for (int i = 0; i < NCH; i++) begin
          d = int'(div[i*DIV_W +: DIV_W]);
          if (mode == 2'b00) begin
            if (m_cnt[i] >= d) begin m_cnt[i] = 0; m_tick[i] = 1'b1; end
            else begin m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 1'b0; end
          end else if (mode == 2'b10 && step && !old_q) begin
            m_cnt[i] = 0; m_tick[i] = 1'b1;
          end else begin
            m_tick[i] = 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_resetn", 32'(resetn), 32'(m_resetn));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_running", 32'(running), 32'(m_running));
    end
  end

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold_phase();
    for (int k = 1; k <= int'(RC); k++) begin
      edge1();
      chk("hold_resetn", 32'(resetn), 32'(k >= int'(RC)));
      chk("hold_tick", 32'(tick), 32'd0);
      if (mode != 2'b00 || k < int'(RC)) chk("hold_running", 32'(running), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; mode = 2'b01; step = 1'b0;
    div = {8'd3, 8'd0};
    repeat (3) edge1();
    chk("rst_resetn", 32'(resetn), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_running", 32'(running), 32'd0);

    // Reset stretch
    RESET = 1'b0;
    hold_phase();

    // RUN periods: div0=0 every edge, div1=3 every 4th edge
    mode = 2'b00;
    for (int r = 1; r <= 10; r++) begin
      edge1();
      chk("run_tick", 32'(tick), 32'({(r % 4) == 0, 1'b1}));
      chk("run_running", 32'(running), 32'd1);
    end

    // Pause with cnt1=2, then resume: tick1 two RUN edges later
    mode = 2'b01;
    for (int p = 0; p < 5; p++) begin
      edge1();
      chk("pause_tick", 32'(tick), 32'd0);
      chk("pause_running", 32'(running), 32'd0);
    end
    mode = 2'b00;
    edge1(); chk("resume1_tick", 32'(tick), 32'b01);
    edge1(); chk("resume2_tick", 32'(tick), 32'b11);

    // Divisor shrink: div1 10 -> 2 at cnt1=7
    div[15:8] = 8'd10;
    for (int s = 0; s < 7; s++) begin
      edge1();
      chk("pre_shrink_tick", 32'(tick), 32'b01);
    end
    div[15:8] = 8'd2;
    for (int s = 1; s <= 7; s++) begin
      edge1();
      chk("shrink_tick", 32'(tick), 32'({(s % 3) == 1, 1'b1}));
    end

    // STEP: one tick for a step held 10 edges
    mode = 2'b10;
    edge1();
    chk("step_idle_tick", 32'(tick), 32'd0);
    step = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      edge1();
      chk("step_tick", 32'(tick), (s == 1) ? 32'b11 : 32'b00);
      chk("step_running", 32'(running), 32'd0);
    end
    step = 1'b0;
    edge1();

    // Reset mid-run, then step held across reset/hold
    mode = 2'b00;
    repeat (3) edge1();
    RESET = 1'b1; step = 1'b1; mode = 2'b10;
    edge1();
    chk("midrst_resetn", 32'(resetn), 32'd0);
    chk("midrst_tick", 32'(tick), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    RESET = 1'b0;
    hold_phase();
    for (int s = 0; s < 5; s++) begin
      edge1();
      chk("held_step_tick", 32'(tick), 32'd0);
    end

    // RUN after reset restarts counts from 0 (div1=2)
    mode = 2'b00; step = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      edge1();
      chk("rerun_tick", 32'(tick), 32'({r == 3, 1'b1}));
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
